// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - interrupt source controller: sync, polarity, edge/level detect, pending/enable, bus slave
module irq_ctrl #(
    parameter int IRQ_CH      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs_,
    input  logic              as_,
    input  logic              rw,
    input  logic [1:0]        addr,
    input  logic [31:0]       wr_data,
    output logic [31:0]       rd_data,
    output logic              rdy_,
    input  logic [IRQ_CH-1:0] src,
    output logic [IRQ_CH-1:0] irq
);

    logic [IRQ_CH-1:0] sync_q [SYNC_STAGES];
    logic [IRQ_CH-1:0] pending, mode, polarity, enable, prev;

    logic              access, wr_en;
    logic [IRQ_CH-1:0] wr_bits, s, n, n_new;
    logic [IRQ_CH-1:0] mode_nx, pol_nx, en_nx, w1c, changed, edge_set;
    logic [IRQ_CH-1:0] pend_nx, prev_nx;
    logic [31:0]       rd_val;

    generate
        if (IRQ_CH < 32) begin : g_unused
            logic unused_hi;
            assign unused_hi = ^wr_data[31:IRQ_CH];
        end
    endgenerate

    always_comb begin
        access  = !cs_ && !as_;
        wr_en   = access && !rw;
        wr_bits = wr_data[IRQ_CH-1:0];

        s = sync_q[SYNC_STAGES-1];
        n = ~(s ^ polarity);

        mode_nx = (wr_en && addr == 2'd1) ? wr_bits : mode;
        pol_nx  = (wr_en && addr == 2'd2) ? wr_bits : polarity;
        en_nx   = (wr_en && addr == 2'd3) ? wr_bits : enable;
        w1c     = (wr_en && addr == 2'd0) ? wr_bits : '0;

        // A channel whose detection config changes restarts cleanly: history
        // is reloaded with the value seen under the new polarity.
        changed = (mode_nx ^ mode) | (pol_nx ^ polarity);
        n_new   = ~(s ^ pol_nx);

        edge_set = n & ~prev;
        pend_nx  = ((mode & (edge_set | (pending & ~w1c))) | (~mode & n)) & ~changed;
        prev_nx  = (changed & n_new) | (~changed & n);

        rd_val = '0;
        case (addr)
            2'd0:    rd_val[IRQ_CH-1:0] = pending;
            2'd1:    rd_val[IRQ_CH-1:0] = mode;
            2'd2:    rd_val[IRQ_CH-1:0] = polarity;
            default: rd_val[IRQ_CH-1:0] = enable;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= src;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending  <= '0;
            mode     <= '0;
            polarity <= '1;
            enable   <= '0;
            prev     <= '0;
            irq      <= '0;
            rd_data  <= '0;
            rdy_     <= 1'b1;
        end else begin
            pending  <= pend_nx;
            mode     <= mode_nx;
            polarity <= pol_nx;
            enable   <= en_nx;
            prev     <= prev_nx;
            irq      <= pending & enable;
            rd_data  <= (access && rw) ? rd_val : '0;
            rdy_     <= !access;
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - scoreboard bench for irq_ctrl against a per-channel reference model
module tb_irq_ctrl;

    localparam int CH = 8;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cs_ = 1'b1, as_ = 1'b1, rw = 1'b1;
    logic [1:0]    addr = '0;
    logic [31:0]   wr_data = '0;
    logic [31:0]   rd_data;
    logic          rdy_;
    logic [CH-1:0] src = '0;
    logic [CH-1:0] irq;

    irq_ctrl #(.IRQ_CH(CH), .SYNC_STAGES(SS)) dut (
        .clk(clk), .reset(reset), .cs_(cs_), .as_(as_), .rw(rw), .addr(addr),
        .wr_data(wr_data), .rd_data(rd_data), .rdy_(rdy_), .src(src), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_rd;
        logic [31:0] data;
    } acc_t;

    logic [CH-1:0] irq_q[$];
    logic          rdy_q[$];
    acc_t          acc_q[$];

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: register file plus a queue holding the last SS src samples.
    initial begin
        logic [CH-1:0] m_pend, m_mode, m_pol, m_en, m_prev;
        logic [CH-1:0] m_sh[$];
        logic [CH-1:0] nm, np, ne, w1c, pend_n, prev_n, sh0;
        logic          s_b, n_b, acc;
        acc_t          a;
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_pend = '0; m_mode = '0; m_pol = '1; m_en = '0; m_prev = '0;
                m_sh.delete();
                for (int k = 0; k < SS; k++) m_sh.push_back('0);
                irq_q.delete(); rdy_q.delete(); acc_q.delete();
            end else begin
                acc = !cs_ && !as_;
                nm  = (acc && !rw && addr == 2'd1) ? wr_data[CH-1:0] : m_mode;
                np  = (acc && !rw && addr == 2'd2) ? wr_data[CH-1:0] : m_pol;
                ne  = (acc && !rw && addr == 2'd3) ? wr_data[CH-1:0] : m_en;
                w1c = (acc && !rw && addr == 2'd0) ? wr_data[CH-1:0] : '0;
                sh0 = m_sh[0];
                for (int i = 0; i < CH; i++) begin
                    s_b = sh0[i];
                    n_b = m_pol[i] ? s_b : !s_b;
                    if (nm[i] != m_mode[i] || np[i] != m_pol[i]) begin
                        pend_n[i] = 1'b0;
                        prev_n[i] = np[i] ? s_b : !s_b;
                    end else begin
                        prev_n[i] = n_b;
                        if (!m_mode[i])                pend_n[i] = n_b;
                        else if (n_b && !m_prev[i])    pend_n[i] = 1'b1;
                        else if (w1c[i])               pend_n[i] = 1'b0;
                        else                           pend_n[i] = m_pend[i];
                    end
                end
                irq_q.push_back(m_pend & m_en);
                rdy_q.push_back(acc);
                if (acc) begin
                    a.is_rd = rw;
                    case (addr)
                        2'd0:    a.data = {24'h0, m_pend};
                        2'd1:    a.data = {24'h0, m_mode};
                        2'd2:    a.data = {24'h0, m_pol};
                        default: a.data = {24'h0, m_en};
                    endcase
                    acc_q.push_back(a);
                end
                m_pend = pend_n; m_prev = prev_n;
                m_mode = nm; m_pol = np; m_en = ne;
                void'(m_sh.pop_front());
                m_sh.push_back(src);
            end
        end
    end

    // Monitor: compares DUT outputs away from the active edge.
    initial begin
        logic [CH-1:0] e_irq;
        logic          e_acc;
        acc_t          a;
        forever begin
            @(negedge clk);
            if (!reset) begin
                check("reset_irq", {24'h0, irq}, 32'h0);
                check("reset_rdy", {31'h0, rdy_}, 32'h1);
                check("reset_rd_data", rd_data, 32'h0);
            end else if (irq_q.size() > 0) begin
                e_irq = irq_q.pop_front();
                e_acc = rdy_q.pop_front();
                check("irq", {24'h0, irq}, {24'h0, e_irq});
                check("rdy_", {31'h0, rdy_}, {31'h0, !e_acc});
                if (!rdy_) begin
                    if (acc_q.size() == 0) begin
                        n_checks++; n_fails++;
                        $display("FAIL rdy_unexpected: got rdy_=0 expected no response at %0t", $time);
                    end else begin
                        a = acc_q.pop_front();
                        if (a.is_rd) check("rd_data", rd_data, a.data);
                    end
                end else begin
                    check("idle_rd_data", rd_data, 32'h0);
                end
            end
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus(input logic r, input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        cs_ = 1'b0; as_ = 1'b0; rw = r; addr = a; wr_data = d;
        @(negedge clk);
        cs_ = 1'b1; as_ = 1'b1;
    endtask

    task automatic pulse(input int ch);
        @(negedge clk); src[ch] = 1'b1;
        @(negedge clk); src[ch] = 1'b0;
    endtask

    initial begin
        idle(3);
        reset = 1'b1;
        // reset values and readback
        idle(2);
        for (int r = 0; r < 4; r++) bus(1'b1, 2'(r), 32'h0);
        // edge, active-high, channel 0
        bus(1'b0, 2'd1, 32'h01);
        bus(1'b0, 2'd3, 32'h01);
        pulse(0); idle(4);
        bus(1'b0, 2'd0, 32'h01); idle(2);
        pulse(0); idle(4);
        // level, active-low, channel 1
        bus(1'b0, 2'd2, 32'hFD);
        bus(1'b0, 2'd3, 32'h02);
        idle(4);
        bus(1'b0, 2'd0, 32'h02); idle(3);
        src[1] = 1'b1; idle(4);
        // simultaneous edge-set and W1C on channel 2
        bus(1'b0, 2'd1, 32'h05);
        bus(1'b0, 2'd3, 32'h04);
        pulse(2);
        bus(1'b0, 2'd0, 32'h04); idle(3);
        bus(1'b1, 2'd0, 32'h0);
        // masking, then polarity toggle on a steady-high edge channel
        bus(1'b0, 2'd3, 32'h00);
        bus(1'b0, 2'd1, 32'h18);
        pulse(3); idle(4);
        bus(1'b1, 2'd0, 32'h0);
        bus(1'b0, 2'd3, 32'h08); idle(2);
        @(negedge clk); src[4] = 1'b1; idle(5);
        bus(1'b0, 2'd0, 32'h10);
        bus(1'b0, 2'd2, 32'hED); idle(3);
        bus(1'b0, 2'd2, 32'hFD); idle(3);
        bus(1'b1, 2'd0, 32'h0);
        // back-to-back reads with the strobe held
        @(negedge clk); cs_ = 1'b0; as_ = 1'b0; rw = 1'b1;
        for (int r = 0; r < 4; r++) begin addr = 2'(r); @(negedge clk); end
        cs_ = 1'b1; as_ = 1'b1;
        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            src = CH'($urandom);
            if ($urandom_range(9) < 3) begin
                cs_ = 1'b0; as_ = 1'b0; rw = 1'($urandom);
                addr = 2'($urandom); wr_data = $urandom;
            end else begin
                cs_ = 1'b1; as_ = 1'b1;
            end
        end
        @(negedge clk); cs_ = 1'b1; as_ = 1'b1; src = '0;
        idle(6);
        // reset in the middle of a write to ENABLE
        @(negedge clk);
        cs_ = 1'b0; as_ = 1'b0; rw = 1'b0; addr = 2'd3; wr_data = 32'hFF;
        #2 reset = 1'b0;
        idle(2);
        cs_ = 1'b1; as_ = 1'b1;
        @(negedge clk); reset = 1'b1;
        idle(1);
        bus(1'b1, 2'd3, 32'h0);
        idle(4);
        check("responses_outstanding", acc_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
